// File: rtl/eae_pkg.sv
// Shared EAE definitions: divider state encoding and the common datapath word width.
package eae_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int EAE_WIDTH = 12;

endpackage

// File: rtl/eae_divider_if.sv
// Operand/result bundle between the EAE sequencer (master) and the divider (slave).
interface eae_divider_if
  import eae_pkg::*;
#(
  parameter int WIDTH = EAE_WIDTH
) ();

  logic                 start;
  logic                 abort;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 link_out;
  logic                 div_zero;

  modport master (
    output start, abort, dividend, divisor,
    input  busy, done, quotient, remainder, link_out, div_zero
  );

  modport slave (
    input  start, abort, dividend, divisor,
    output busy, done, quotient, remainder, link_out, div_zero
  );

endinterface

// File: rtl/eae_divider_div_step.sv
// One restoring-division step: trial-subtract M from the top W+1 bits of P and shift.
module div_step
  import eae_pkg::*;
#(
  parameter int WIDTH = EAE_WIDTH
) (
  input  logic [2*WIDTH-1:0] p_cur,
  input  logic [WIDTH-1:0]   m_val,
  output logic [2*WIDTH-1:0] p_next,
  output logic               sub_ok
);

  logic [WIDTH:0] t_s;

  // Trial difference and the shifted partial remainder/quotient
  always_comb begin
    t_s    = p_cur[2*WIDTH-1:WIDTH-1] - {1'b0, m_val};
    sub_ok = ~t_s[WIDTH];
    if (sub_ok) begin
      p_next = {t_s[WIDTH-1:0], p_cur[WIDTH-2:0], 1'b1};
    end else begin
      p_next = {p_cur[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/eae_divider.sv
// EAE DVI unit: unsigned 2W/W restoring divider, one quotient bit per clock,
// with overflow/divide-by-zero detection and abort.
module eae_divider
  import eae_pkg::*;
#(
  parameter int WIDTH = EAE_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  eae_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t           state_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]     m_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 link_r;
  logic                 dz_r;

  logic [2*WIDTH-1:0]   p_next_s;
  logic                 sub_ok_s;
  logic                 ovf_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_cur  (p_r),
    .m_val  (m_r),
    .p_next (p_next_s),
    .sub_ok (sub_ok_s)
  );

  // A zero divisor always lands here since any high half is >= 0
  assign ovf_s = (p_r[2*WIDTH-1:WIDTH] >= m_r);

  // Sequencer: state, working registers, counter and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      p_r     <= {(2*WIDTH){1'b0}};
      m_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      link_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            p_r     <= bus.dividend;
            m_r     <= bus.divisor;
            link_r  <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (bus.abort) begin
            busy_r  <= 1'b0;
            link_r  <= 1'b0;
            dz_r    <= 1'b0;
            state_r <= IDLE;
          end else if (ovf_s) begin
            // P is left alone so AC/MQ echo the dividend, as DVI does
            link_r  <= 1'b1;
            dz_r    <= (m_r == {WIDTH{1'b0}});
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_r  <= 1'b0;
            link_r  <= 1'b0;
            dz_r    <= 1'b0;
            state_r <= IDLE;
          end else begin
            p_r   <= sub_ok_s ? p_next_s : {p_r[2*WIDTH-2:0], 1'b0};
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = p_r[WIDTH-1:0];
  assign bus.remainder = p_r[2*WIDTH-1:WIDTH];
  assign bus.link_out  = link_r;
  assign bus.div_zero  = dz_r;

endmodule

// File: tb/tb_eae_divider.sv
// Directed bench for eae_divider (W=12): reference results from a behavioural
// model go into a scoreboard queue at launch and are checked when done pulses.
module tb_eae_divider;

  localparam int W = 12;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         link;
    logic         dz;
    int           lat;
    int           busy_cycles;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  eae_divider_if #(.WIDTH(W)) bus ();

  eae_divider #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    logic [2*W-1:0] wide_dvs;
    logic [2*W-1:0] qq;
    logic [2*W-1:0] rr;
    wide_dvs = {{W{1'b0}}, dvs};
    if (dvd[2*W-1:W] >= dvs) begin
      e.q = dvd[W-1:0];
      e.r = dvd[2*W-1:W];
      e.link = 1'b1;
      e.dz = (dvs == {W{1'b0}});
      e.lat = 2;
      e.busy_cycles = 1;
    end else begin
      qq = dvd / wide_dvs;
      rr = dvd % wide_dvs;
      e.q = qq[W-1:0];
      e.r = rr[W-1:0];
      e.link = 1'b0;
      e.dz = 1'b0;
      e.lat = W + 2;
      e.busy_cycles = W + 1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    sb.push_back(model(dvd, dvs));
  endtask

  // Waits for done, then pops the oldest expectation and compares everything
  task automatic await_done(input string tag, input int lat0, input int busy0, input bit drop_start);
    int   lat;
    int   busy_n;
    bit   both;
    bit   seen;
    exp_t e;
    lat = lat0;
    busy_n = busy0;
    both = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      @(posedge clock);
      lat++;
      #1;
      if (drop_start) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
      end
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) both = 1'b1;
      seen = bus.done;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"},  {20'd0, bus.quotient},  {20'd0, e.q});
      check({tag, "_remainder"}, {20'd0, bus.remainder}, {20'd0, e.r});
      check({tag, "_link"},      {31'd0, bus.link_out},  {31'd0, e.link});
      check({tag, "_div_zero"},  {31'd0, bus.div_zero},  {31'd0, e.dz});
      check({tag, "_latency"},   lat,    e.lat);
      check({tag, "_busy_cyc"},  busy_n, e.busy_cycles);
    end
    check({tag, "_busy_done_overlap"}, {31'd0, both}, 32'd0);
    @(posedge clock);
    #1;
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.dividend = 24'd0;
    bus.divisor  = 12'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_done",      {31'd0, bus.done},      32'd0);
    check("rst_quotient",  {20'd0, bus.quotient},  32'd0);
    check("rst_remainder", {20'd0, bus.remainder}, 32'd0);
    check("rst_link",      {31'd0, bus.link_out},  32'd0);
    check("rst_div_zero",  {31'd0, bus.div_zero},  32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    launch(24'd100, 12'd7);
    await_done("n100_7", 0, 0, 1'b1);
    launch(24'hFFEFFF, 12'hFFF);
    await_done("maxq", 0, 0, 1'b1);
    launch(24'h123456, 12'h123);
    await_done("ovf_eq", 0, 0, 1'b1);
    launch(24'h000010, 12'h000);
    await_done("dz", 0, 0, 1'b1);
    // Results stay visible in IDLE
    repeat (3) @(posedge clock);
    #1;
    check("hold_dz",       {31'd0, bus.div_zero},  32'd1);
    check("hold_quotient", {20'd0, bus.quotient},  32'h010);

    // Abort sampled at the end of RUN cycle 5
    bus.start = 1'b1;
    bus.dividend = 24'd1000;
    bus.divisor = 12'd9;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.abort = 1'b1;
    @(posedge clock);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", {31'd0, bus.busy},     32'd0);
    check("abort_done", {31'd0, bus.done},     32'd0);
    check("abort_link", {31'd0, bus.link_out}, 32'd0);
    @(posedge clock);
    #1;
    check("abort_no_done", {31'd0, bus.done}, 32'd0);
    // start beats a simultaneous abort in IDLE
    bus.abort = 1'b1;
    launch(24'd50, 12'd6);
    await_done("n50_6", 0, 0, 1'b1);

    // Asynchronous reset during RUN cycle 7
    bus.start = 1'b1;
    bus.dividend = 24'd100;
    bus.divisor = 12'd7;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy",      {31'd0, bus.busy},      32'd0);
    check("arst_quotient",  {20'd0, bus.quotient},  32'd0);
    check("arst_remainder", {20'd0, bus.remainder}, 32'd0);
    check("arst_done",      {31'd0, bus.done},      32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    launch(24'd100, 12'd7);
    await_done("post_rst", 0, 0, 1'b1);

    // start held across DONE; operands swapped after acceptance
    launch(24'd200, 12'd13);
    @(posedge clock);
    #1;
    bus.dividend = 24'h0ABCDE;
    bus.divisor  = 12'h5A3;
    sb.push_back(model(24'h0ABCDE, 12'h5A3));
    await_done("held_a", 1, bus.busy ? 1 : 0, 1'b0);
    check("dead_idle_busy", {31'd0, bus.busy}, 32'd0);
    await_done("held_b", 0, 0, 1'b1);

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
